// File: rtl/gpo_cmd_master.sv
// gpo_cmd_master: host-side GPO/GPI command initiator with optional 64-bit BER_H chaining
module gpo_cmd_master #(
  parameter int NB_CMD        = 8,
  parameter int NB_DATA       = 23,
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int NB_CNT        = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [NB_CMD-1:0]  i_req_cmd,
  input  logic [NB_DATA-1:0] i_req_data,
  input  logic               i_req_wide,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [63:0]        o_rsp_data,
  output logic [31:0]        o_gpo,
  input  logic [31:0]        i_gpi,
  output logic               o_busy
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, SETTLE, RESP} state_t;
  localparam logic [NB_CNT-1:0] HOLD_LAST   = NB_CNT'(HOLD_CYCLES - 1);
  localparam logic [NB_CNT-1:0] SETTLE_LAST = NB_CNT'(SETTLE_CYCLES - 1);
  localparam logic [NB_CMD-1:0] CMD_BER_H   = NB_CMD'(11);
  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_CMD-1:0]   cmd_q, cmd_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic                wide_q, wide_d, ph2_q, ph2_d;
  logic [63:0]         rsp_q, rsp_d;
  logic [31:0]         gpo_q, gpo_d;
  // next-state: latch request, time strobe/settle phases, sample GPI, chain BER_H for wide reads
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    wide_d  = wide_q;
    ph2_d   = ph2_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: if (i_req_valid) begin
        state_d = SETUP;
        cmd_d   = i_req_cmd;
        data_d  = i_req_data;
        wide_d  = i_req_wide;
        ph2_d   = 1'b0;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: if (cnt_q == HOLD_LAST) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      SETTLE: if (cnt_q == SETTLE_LAST) begin
        if (ph2_q) begin
          rsp_d[63:32] = i_gpi;
          state_d      = RESP;
        end else begin
          rsp_d   = {32'b0, i_gpi};
          state_d = wide_q ? SETUP : RESP;
          cmd_d   = wide_q ? CMD_BER_H : cmd_q;
          data_d  = wide_q ? '0 : data_q;
          ph2_d   = wide_q;
        end
      end else cnt_d = cnt_q + 1'b1;
      RESP: if (i_rsp_ready) begin
        state_d = IDLE;
        wide_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    gpo_d = (state_d == IDLE || state_d == RESP) ? {gpo_q[31:NB_DATA+1], 1'b0, gpo_q[NB_DATA-1:0]}
                                                 : {cmd_d, state_d == STROBE, data_d};
  end
  // state and datapath registers; GPO is registered so it follows the state exactly
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      wide_q  <= 1'b0;
      ph2_q   <= 1'b0;
      rsp_q   <= '0;
      gpo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      wide_q  <= wide_d;
      ph2_q   <= ph2_d;
      rsp_q   <= rsp_d;
      gpo_q   <= gpo_d;
    end
  end
  assign o_req_ready = state_q == IDLE;
  assign o_busy      = state_q != IDLE;
  assign o_rsp_valid = state_q == RESP;
  assign o_rsp_data  = rsp_q;
  assign o_gpo       = gpo_q;
endmodule

// File: tb/tb_gpo_cmd_master.sv
// tb_gpo_cmd_master: directed checks of the GPO command master with a small GPI model
module tb_gpo_cmd_master;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [7:0]  i_req_cmd = '0;
  logic [22:0] i_req_data = '0;
  logic        i_req_wide = 1'b0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [63:0] o_rsp_data;
  logic [31:0] o_gpo;
  logic [31:0] i_gpi;
  logic        o_busy;
  logic [31:0] gpi_lo = '0, gpi_hi = '0;
  logic        en_prev = 1'b0;
  int          rises = 0;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] held;

  gpo_cmd_master dut (
    .clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_cmd(i_req_cmd), .i_req_data(i_req_data), .i_req_wide(i_req_wide),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_gpo(o_gpo), .i_gpi(i_gpi), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  assign i_gpi = (o_gpo[31:24] == 8'd11) ? gpi_hi : gpi_lo;

  always @(posedge clk) begin
    en_prev <= o_gpo[23];
    if (o_gpo[23] === 1'b1 && en_prev !== 1'b1) rises <= rises + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] c, input logic [22:0] d, input logic w);
    i_req_cmd   = c;
    i_req_data  = d;
    i_req_wide  = w;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
  endtask

  initial begin
    // 1: reset
    tick(); tick();
    chk("rst_gpo", 64'(o_gpo), 64'h0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'h0);
    chk("rst_ready", 64'(o_req_ready), 64'h1);
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_rsp_data", o_rsp_data, 64'h0);
    i_rst = 1'b0;
    tick();
    // 2: narrow EN_TX
    gpi_lo = 32'h0000_0001;
    accept(8'd1, 23'd1, 1'b0);
    chk("n_setup_gpo", 64'(o_gpo), 64'h0100_0001);
    chk("n_busy", 64'(o_busy), 64'h1);
    chk("n_ready", 64'(o_req_ready), 64'h0);
    tick(); chk("n_strobe1", 64'(o_gpo), 64'h0180_0001);
    tick(); chk("n_strobe2", 64'(o_gpo), 64'h0180_0001);
    tick(); chk("n_settle1", 64'(o_gpo), 64'h0100_0001);
    tick(); tick(); tick();
    chk("n_settle4", 64'(o_gpo), 64'h0100_0001);
    chk("n_valid_early", 64'(o_rsp_valid), 64'h0);
    tick();
    chk("n_valid", 64'(o_rsp_valid), 64'h1);
    chk("n_data", o_rsp_data, 64'h0000_0000_0000_0001);
    chk("n_rises", 64'(rises), 64'd1);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("n_done_valid", 64'(o_rsp_valid), 64'h0);
    chk("n_done_ready", 64'(o_req_ready), 64'h1);
    // 3: wide BER_S_I
    gpi_lo = 32'h53BC_DE21;
    gpi_hi = 32'h0AFB_2344;
    accept(8'd7, 23'd0, 1'b1);
    chk("w_setup1", 64'(o_gpo), 64'h0700_0000);
    tick(); chk("w_strobe1", 64'(o_gpo), 64'h0780_0000);
    repeat (6) tick();
    chk("w_setup2", 64'(o_gpo), 64'h0B00_0000);
    chk("w_busy", 64'(o_busy), 64'h1);
    tick(); chk("w_strobe2a", 64'(o_gpo), 64'h0B80_0000);
    tick(); chk("w_strobe2b", 64'(o_gpo), 64'h0B80_0000);
    tick(); chk("w_settle2", 64'(o_gpo), 64'h0B00_0000);
    repeat (3) tick();
    chk("w_valid_early", 64'(o_rsp_valid), 64'h0);
    tick();
    chk("w_valid", 64'(o_rsp_valid), 64'h1);
    chk("w_data", o_rsp_data, 64'h0AFB_2344_53BC_DE21);
    chk("w_rsp_gpo", 64'(o_gpo), 64'h0B00_0000);
    chk("w_rises", 64'(rises), 64'd3);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("w_done_ready", 64'(o_req_ready), 64'h1);
    // 4: READ_MEM
    gpi_lo = 32'h1234_5678;
    accept(8'd5, 23'h35EB1C, 1'b0);
    chk("r_setup", 64'(o_gpo), 64'h0535_EB1C);
    tick(); chk("r_strobe1", 64'(o_gpo), 64'h05B5_EB1C);
    tick(); chk("r_strobe2", 64'(o_gpo), 64'h05B5_EB1C);
    tick(); chk("r_settle", 64'(o_gpo), 64'h0535_EB1C);
    repeat (4) tick();
    chk("r_valid", 64'(o_rsp_valid), 64'h1);
    chk("r_data", o_rsp_data, 64'h0000_0000_1234_5678);
    // 5: backpressure with a pending request
    held = o_rsp_data;
    i_req_cmd   = 8'd9;
    i_req_data  = 23'h00_0042;
    i_req_wide  = 1'b0;
    i_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 64'(o_rsp_valid), 64'h1);
      chk("bp_data", o_rsp_data, held);
      chk("bp_ready", 64'(o_req_ready), 64'h0);
    end
    chk("bp_rises", 64'(rises), 64'd4);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("bp_idle_ready", 64'(o_req_ready), 64'h1);
    chk("bp_idle_valid", 64'(o_rsp_valid), 64'h0);
    tick();
    i_req_valid = 1'b0;
    chk("bp_accept_busy", 64'(o_busy), 64'h1);
    chk("bp_accept_gpo", 64'(o_gpo), 64'h0900_0042);
    // 6: reset during the second strobe cycle
    tick(); tick();
    chk("rr_strobe2", 64'(o_gpo), 64'h0980_0042);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rr_gpo", 64'(o_gpo), 64'h0);
    chk("rr_ready", 64'(o_req_ready), 64'h1);
    chk("rr_busy", 64'(o_busy), 64'h0);
    chk("rr_rises", 64'(rises), 64'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rr_no_rsp", 64'(o_rsp_valid), 64'h0);
    end
    chk("rr_gpo_quiet", 64'(o_gpo), 64'h0);
    chk("rr_rises_end", 64'(rises), 64'd5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpo_cmd_master.md
Name: gpo_cmd_master

Overview:
Host-side initiator for the register-file GPO/GPI command protocol. Accepts command requests over a valid/ready interface and drives the 32-bit GPO word: command in [31:24], enable strobe in [23], payload in [22:0]. After a settle time it samples the 32-bit GPI word and returns it as a response. For 64-bit counters (BER samples/errors) it optionally chains a second BER_H (8'd11) command and returns both halves concatenated.

Parameters:
NB_CMD, 8, command field width (GPO[31:24])
NB_DATA, 23, payload field width (GPO[22:0])
HOLD_CYCLES, 2, cycles the enable bit GPO[23] stays high per command (>=1)
SETTLE_CYCLES, 4, cycles after enable falls before GPI is sampled (>=1)
NB_CNT, 8, width of the internal phase counter (must hold max(HOLD_CYCLES, SETTLE_CYCLES))

Ports:
clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_req_valid  in  1  command request valid
o_req_ready  out  1  high only in IDLE; request accepted when valid&&ready
i_req_cmd  in  NB_CMD  command code
i_req_data  in  NB_DATA  command payload
i_req_wide  in  1  1: follow the command with BER_H and return 64 bits
o_rsp_valid  out  1  response valid, held until accepted
i_rsp_ready  in  1  response consumer ready
o_rsp_data  out  64  narrow: {32'b0, GPI}; wide: {GPI_high, GPI_low}
o_gpo  out  32  GPO word to the register file
i_gpi  in  32  GPI word from the register file
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, i_rst=1 at an edge): state=IDLE, o_gpo=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, o_req_ready=1, wide flag cleared. Reset overrides all other activity in the same cycle.
- FSM states: IDLE, SETUP, STROBE, SETTLE, RESP.
- IDLE: on valid&&ready, latch cmd, data and wide, then go to SETUP. Later changes on the request inputs are ignored.
- SETUP (1 cycle): o_gpo={cmd,1'b0,data}. Cmd and data are stable before the strobe rises.
- STROBE (HOLD_CYCLES cycles): o_gpo={cmd,1'b1,data}.
- SETTLE (SETTLE_CYCLES cycles): o_gpo={cmd,1'b0,data}, held.
- On the edge ending the last SETTLE cycle, i_gpi is sampled:
  - First phase: captured into the low word.
  - Wide and first phase: reload cmd=8'd11, data=0, enter SETUP for the second phase.
  - Second phase: captured into the high word.
  - Otherwise: go to RESP.
- RESP: o_rsp_valid=1, o_rsp_data stable. On i_rsp_ready go to IDLE (o_rsp_valid=0 at the next edge). o_gpo keeps its last value, with the enable bit at 0.
- Latency from the acceptance edge to o_rsp_valid high:
  - Narrow: 1+HOLD_CYCLES+SETTLE_CYCLES edges (7 with defaults).
  - Wide: 2×(1+HOLD_CYCLES+SETTLE_CYCLES) (14 with defaults).
- o_req_ready=0 in RESP, so a request cannot be accepted in the same cycle as the response handshake. Earliest next acceptance is the cycle after.
- Exactly one rising edge of GPO[23] per command phase, and never two without a low cycle between them.
- Reset mid-operation: at the next edge o_gpo=0, the enable drops with no further strobe, any pending response is discarded, and the block is in IDLE.
- Narrow response: upper 32 bits of o_rsp_data are 0.
- i_req_wide is honoured for any command code, with no decode.

Test Plan:
1. i_rst=1 for 2 cycles → o_gpo=0, o_rsp_valid=0, o_req_ready=1, o_busy=0.
2. Narrow EN_TX: cmd=8'd1, data=23'd1, GPI model returns 0x0000_0001 → o_gpo is 0x01000001 for 1 cycle, 0x01800001 for 2 cycles, then 0x01000001 for 4 cycles; o_rsp_valid rises 7 edges after acceptance with o_rsp_data=0x0000000000000001.
3. Wide BER_S_I: cmd=8'd7, wide=1, GPI model returns 0x53BCDE21 then 0x0AFB2344 → second strobe shows o_gpo=0x0B800000; o_rsp_data=0x0AFB234453BCDE21 after 14 edges.
4. READ_MEM: cmd=8'd5, data=23'h35EB1C → strobe o_gpo=0x05B5EB1C for exactly 2 cycles.
5. Backpressure: hold i_rsp_ready=0 for 10 cycles with i_req_valid=1 → o_rsp_valid and o_rsp_data stable, o_req_ready=0, no new strobe. Raise ready → IDLE next edge; the new request is accepted the following cycle.
6. Assert i_rst during the 2nd STROBE cycle → o_gpo=0 at the next edge, no further GPO[23] pulse, o_rsp_valid never asserts, o_req_ready=1.
